instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 32 +++
 rtl/instr_fifo2.sv | 49 ++++
 rtl/instr_encoder.sv | 90 +++++++++
 tb/tb_instr_encoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared LEGv8 definitions: mnemonic codes, opcode fields (same values SingleCycleControl decodes)
// and the buffered word type used by the encoder and its output FIFO.
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    OP_LDUR = 4'd0,
    OP_STUR = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_ORR  = 4'd5,
    OP_CBZ  = 4'd6,
    OP_B    = 4'd7
  } op_e;

  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [5:0]  OPC_B    = 6'b000101;

  localparam int unsigned ADDR_W = 64;

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
  } instr_entry_t;

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry FIFO of {instr, addr} with synchronous flush; head is presented combinationally.
module instr_fifo2
  import instr_encoder_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  instr_entry_t i_data,
  output instr_entry_t o_data,
  output logic         o_valid,
  output logic         o_full
);

  instr_entry_t r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign o_valid = (r_cnt != 2'd0);
  assign o_full  = (r_cnt == 2'd2);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && o_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder: turns mnemonic requests into 32-bit words tagged with a
// running byte address and streams them through a 2-deep buffer to the memory writer.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              Load,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [3:0]        Op,
  input  logic [4:0]        Rd,
  input  logic [4:0]        Rn,
  input  logic [4:0]        Rm,
  input  logic [25:0]       Imm,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic [31:0]       Instr,
  output logic [ADDR_W-1:0] InstrAddr,
  output logic [15:0]       WordCount,
  output logic              Error
);

  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wcnt;
  logic              r_err;
  logic [31:0]       w_instr;
  logic              w_op_ok;
  logic              w_full;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  instr_entry_t      w_wr_ent;
  instr_entry_t      w_rd_ent;

  always_comb begin
    w_instr = '0;
    w_op_ok = 1'b1;
    case (Op)
      OP_LDUR: w_instr = {OPC_LDUR, Imm[8:0], 2'b00, Rn, Rd};
      OP_STUR: w_instr = {OPC_STUR, Imm[8:0], 2'b00, Rn, Rd};
      OP_ADD:  w_instr = {OPC_ADD, Rm, 6'b0, Rn, Rd};
      OP_SUB:  w_instr = {OPC_SUB, Rm, 6'b0, Rn, Rd};
      OP_AND:  w_instr = {OPC_AND, Rm, 6'b0, Rn, Rd};
      OP_ORR:  w_instr = {OPC_ORR, Rm, 6'b0, Rn, Rd};
      OP_CBZ:  w_instr = {OPC_CBZ, Imm[18:0], Rd};
      OP_B:    w_instr = {OPC_B, Imm[25:0]};
      default: w_op_ok = 1'b0;
    endcase
  end

  assign ReqReady = !w_full && !Load;
  assign w_accept = ReqValid && ReqReady;
  assign w_push   = w_accept && w_op_ok;
  // A handshake that coincides with Load is swallowed by the flush and not counted.
  assign w_pop    = InstrValid && InstrReady && !Load;
  assign w_wr_ent = '{instr: w_instr, addr: r_addr};

  instr_fifo2 u_fifo (
    .i_clk   (CLK),
    .i_rst_n (Reset_L),
    .i_flush (Load),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_wr_ent),
    .o_data  (w_rd_ent),
    .o_valid (InstrValid),
    .o_full  (w_full)
  );

  assign Instr     = w_rd_ent.instr;
  assign InstrAddr = w_rd_ent.addr;
  assign WordCount = r_wcnt;
  assign Error     = r_err;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_addr <= '0;
      r_wcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (Load)        r_addr <= StartAddr;
      else if (w_push) r_addr <= r_addr + 64'd4;
      if (w_pop)       r_wcnt <= r_wcnt + 16'd1;
      if (w_accept && !w_op_ok) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed examples plus random traffic against a queue-based model.
module tb_instr_encoder;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic        Load;
  logic [63:0] StartAddr;
  logic        ReqValid;
  logic        ReqReady;
  logic [3:0]  Op;
  logic [4:0]  Rd, Rn, Rm;
  logic [25:0] Imm;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [63:0] InstrAddr;
  logic [15:0] WordCount;
  logic        Error;

  instr_encoder dut (
    .CLK(CLK), .Reset_L(Reset_L), .Load(Load), .StartAddr(StartAddr),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .Op(Op), .Rd(Rd), .Rn(Rn), .Rm(Rm),
    .Imm(Imm), .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr),
    .InstrAddr(InstrAddr), .WordCount(WordCount), .Error(Error)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] i;
    logic [63:0] a;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_cnt;
  logic [15:0] m_wc;
  logic        m_err;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] wc_base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word built from field weights rather than bit concatenation.
  function automatic logic [31:0] ref_enc(input int op, input int rd, input int rn,
                                          input int rm, input longint imm, output bit ok);
    longint w;
    longint r3;
    ok = 1;
    w  = 0;
    r3 = longint'(rm) * 65536 + longint'(rn) * 32 + longint'(rd);
    case (op)
      0: w = 64'h7C2 * 2097152 + (imm % 512) * 4096 + rn * 32 + rd;
      1: w = 64'h7C0 * 2097152 + (imm % 512) * 4096 + rn * 32 + rd;
      2: w = 64'h458 * 2097152 + r3;
      3: w = 64'h658 * 2097152 + r3;
      4: w = 64'h450 * 2097152 + r3;
      5: w = 64'h550 * 2097152 + r3;
      6: w = 64'hB4 * 16777216 + (imm % 524288) * 32 + rd;
      7: w = 5 * 67108864 + imm;
      default: ok = 0;
    endcase
    return w[31:0];
  endfunction

  task automatic model_edge();
    bit          ok;
    logic [31:0] w;
    bit          acc;
    bit          pop;
    acc = ReqValid && (mq.size() < 2) && !Load;
    pop = (mq.size() > 0) && InstrReady && !Load;
    if (Load) begin
      mq.delete();
      m_cnt = StartAddr;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        m_wc = m_wc + 16'd1;
      end
      if (acc) begin
        w = ref_enc(int'(Op), int'(Rd), int'(Rn), int'(Rm), longint'(Imm), ok);
        if (ok) begin
          mq.push_back('{i: w, a: m_cnt});
          m_cnt = m_cnt + 64'd4;
        end else m_err = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("ReqReady", ReqReady, (mq.size() < 2) && !Load);
    chk("InstrValid", InstrValid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("Instr", Instr, mq[0].i);
      chk("InstrAddr", InstrAddr, mq[0].a);
    end
    chk("WordCount", WordCount, m_wc);
    chk("Error", Error, m_err);
  endtask

  task automatic drive(input logic ld, input logic [63:0] sa, input logic rv, input logic [3:0] op,
                       input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                       input logic [25:0] imm, input logic ir);
    Load = ld; StartAddr = sa; ReqValid = rv; Op = op;
    Rd = rd; Rn = rn; Rm = rm; Imm = imm; InstrReady = ir;
    model_edge();
    @(posedge CLK);
    @(negedge CLK);
    check_all();
  endtask

  task automatic idle(input logic ir);
    drive(1'b0, 64'd0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, ir);
  endtask

  task automatic add_req(input logic ir);
    drive(1'b0, 64'd0, 1'b1, 4'd2, 5'($urandom), 5'($urandom), 5'($urandom), 26'd0, ir);
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt = '0;
    m_wc  = '0;
    m_err = 1'b0;
  endtask

  initial begin
    Reset_L = 1'b0; Load = 1'b0; StartAddr = '0; ReqValid = 1'b0; Op = '0;
    Rd = '0; Rn = '0; Rm = '0; Imm = '0; InstrReady = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", InstrValid, 1'b0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_addr", InstrAddr, 64'd0);
    chk("rst_wc", WordCount, 16'd0);
    chk("rst_err", Error, 1'b0);
    @(negedge CLK);
    Reset_L = 1'b1;
    #1 chk("rst_ready", ReqReady, 1'b1);

    // ADD example at 0x1000
    drive(1'b1, 64'h1000, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
    drive(1'b0, 64'd0, 1'b1, 4'd2, 5'd3, 5'd1, 5'd2, 26'd0, 1'b0);
    chk("ex_add", Instr, 32'h8B020023);
    chk("ex_add_addr", InstrAddr, 64'h1000);
    idle(1'b1);

    // LDUR then CBZ
    drive(1'b0, 64'd0, 1'b1, 4'd0, 5'd5, 5'd2, 5'd0, 26'd8, 1'b0);
    drive(1'b0, 64'd0, 1'b1, 4'd6, 5'd7, 5'd0, 5'd0, 26'd3, 1'b0);
    chk("ex_ldur", Instr, 32'hF8408045);
    chk("ex_ldur_addr", InstrAddr, 64'h1004);
    idle(1'b1);
    chk("ex_cbz", Instr, 32'hB4000067);
    chk("ex_cbz_addr", InstrAddr, 64'h1008);
    idle(1'b1);

    // B with all-ones offset, then an invalid op
    drive(1'b0, 64'd0, 1'b1, 4'd7, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 1'b0);
    chk("ex_b", Instr, 32'h17FFFFFF);
    idle(1'b1);
    drive(1'b0, 64'd0, 1'b1, 4'd9, 5'd1, 5'd1, 5'd1, 26'd1, 1'b0);
    chk("inv_err", Error, 1'b1);
    chk("inv_noout", InstrValid, 1'b0);
    add_req(1'b0);
    chk("inv_addr_kept", InstrAddr, 64'h1010);
    idle(1'b1);

    // Backpressure: third request refused until space frees up
    wc_base = m_wc;
    add_req(1'b0);
    add_req(1'b0);
    chk("full_rdy", ReqReady, 1'b0);
    add_req(1'b0);
    add_req(1'b1);
    add_req(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("bp_wc", WordCount, wc_base + 16'd3);

    // Async reset with two words buffered
    add_req(1'b0);
    add_req(1'b0);
    #2 Reset_L = 1'b0;
    Load = 1'b0; ReqValid = 1'b0; InstrReady = 1'b0;
    #1;
    chk("mid_rst_valid", InstrValid, 1'b0);
    chk("mid_rst_wc", WordCount, 16'd0);
    chk("mid_rst_err", Error, 1'b0);
    model_reset();
    @(negedge CLK);
    Reset_L = 1'b1;
    #1 check_all();

    // Load mid-stream flushes and restarts the address counter
    add_req(1'b0);
    add_req(1'b0);
    drive(1'b1, 64'h2000, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
    chk("load_flush", InstrValid, 1'b0);
    add_req(1'b0);
    chk("load_addr", InstrAddr, 64'h2000);

    // Address counter wrap
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
    add_req(1'b1);
    add_req(1'b1);
    chk("wrap_addr", InstrAddr, 64'd0);
    idle(1'b1);

    for (int k = 0; k < 600; k++) begin
      logic        ld;
      logic [63:0] sa;
      logic [3:0]  op;
      ld = ($urandom % 25) == 0;
      sa = ($urandom % 4 == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 : {$urandom, $urandom & 32'hFFFF_FFFC};
      op = ($urandom % 20 == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      drive(ld, sa, ($urandom % 4) != 0, op, 5'($urandom), 5'($urandom), 5'($urandom),
            26'($urandom), ($urandom % 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
